// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. A start request accepted in IDLE latches the
// operands, then one bit per clock is run through a full subtractor, LSB first,
// for WIDTH cycles. A single-cycle done pulse marks the final result.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32), default 8
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  begin a subtraction (sampled only in IDLE)
//   a      minuend, sampled on the accepting edge
//   b      subtrahend, sampled on the accepting edge
//   busy   high while bits are being processed
//   done   one-cycle pulse, result valid
//   diff   a - b modulo 2^WIDTH
//   bout   final borrow (1 iff a < b, unsigned)
//   ovf    two's-complement overflow (only with SERIAL_SUB_OVF_EN)
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf output.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Full subtractor: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bin);
        logic d_v;
        logic bo_v;
        d_v  = ai ^ bi ^ bin;
        bo_v = (~ai & bi) | (~ai & bin) | (bi & bin);
        return {bo_v, d_v};
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   diff_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               borrow_r;
    logic               busy_r;
    logic               done_r;
    logic [1:0]         bit_res_s;
    logic               d_s;
    logic               borrow_next_s;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_sign_r;
    logic               b_sign_r;
    logic               ovf_r;
`endif

    // Per-bit subtraction of the current LSBs with the held borrow.
    always_comb begin
        bit_res_s     = full_sub(a_sh_r[0], b_sh_r[0], borrow_r);
        d_s           = bit_res_s[0];
        borrow_next_s = bit_res_s[1];
    end

    // Control FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            borrow_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_r <= 1'b0;
            b_sign_r <= 1'b0;
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        borrow_r <= 1'b0;
                        cnt_r    <= {CNT_W{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        // Shift registers lose the sign bits, so keep them aside.
                        a_sign_r <= a[WIDTH-1];
                        b_sign_r <= b[WIDTH-1];
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    // New bit enters at the MSB; after WIDTH shifts bit 0 lands at diff[0].
                    diff_r   <= {d_s, diff_r[WIDTH-1:1]};
                    borrow_r <= borrow_next_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_BIT) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        // d_s is the result MSB being shifted in this edge.
                        ovf_r   <= (a_sign_r != b_sign_r) && (d_s != a_sign_r);
`endif
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = borrow_r;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH=8). Expected results come
// from plain integer arithmetic on the operands; latency, done pulse shape,
// start-ignore, mid-operation reset and back-to-back throughput are checked.
// Define SERIAL_SUB_OVF_EN to also check the ovf output.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;
    localparam int N_RANDOM = 2000;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks;
    int n_fail;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .bout  (bout),
        .ovf   (ovf)
`else
        .bout  (bout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] av, input logic [W-1:0] bv);
        int unsigned r;
        r = (int'(av) - int'(bv) + (1 << W)) % (1 << W);
        return r[W-1:0];
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] av, input logic [W-1:0] bv);
        return (int'(av) < int'(bv));
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
        int sa;
        int sb;
        int sd;
        sa = (av >= (1 << (W-1))) ? int'(av) - (1 << W) : int'(av);
        sb = (bv >= (1 << (W-1))) ? int'(bv) - (1 << W) : int'(bv);
        sd = sa - sb;
        return (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
    endfunction

    // Runs one operation. Called at #1 after a rising edge. If inj>0, a
    // spurious start with other operands is applied inj cycles into SHIFT.
    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int inj);
        int lat;
        bit seen;
        start = 1'b1;
        a = av;
        b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check_eq({tag, "_busy_after_accept"}, busy, 1);
        seen = 1'b0;
        lat = 0;
        for (int i = 1; i <= W + 4 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                lat = i;
            end else begin
                if (i == inj) begin
                    start = 1'b1;
                    a = W'($urandom);
                    b = W'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, seen, 1);
        check_eq({tag, "_latency"}, lat, W);
        check_eq({tag, "_diff"}, diff, ref_diff(av, bv));
        check_eq({tag, "_bout"}, bout, ref_bout(av, bv));
        check_eq({tag, "_busy_at_done"}, busy, 0);
`ifdef SERIAL_SUB_OVF_EN
        check_eq({tag, "_ovf"}, ovf, ref_ovf(av, bv));
`endif
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse_end"}, done, 0);
        check_eq({tag, "_diff_held"}, diff, ref_diff(av, bv));
        check_eq({tag, "_bout_held"}, bout, ref_bout(av, bv));
    endtask

    // Counts done pulses over a number of cycles with start low.
    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int extra;
        int done_cyc[$];
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_diff", diff, 0);
        check_eq("reset_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check_eq("reset_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_no_done", done, 0);

        // Directed cases.
        do_op("t35m12", 8'h35, 8'h12, 0);
        do_op("t00m01", 8'h00, 8'h01, 0);
        do_op("tAAmAA", 8'hAA, 8'hAA, 0);
        do_op("tFFm00", 8'hFF, 8'h00, 0);
        do_op("t00mFF", 8'h00, 8'hFF, 0);
        do_op("t80m01", 8'h80, 8'h01, 0);
        do_op("t05m03", 8'h05, 8'h03, 0);
        do_op("t7Fm80", 8'h7F, 8'h80, 0);

        // Start during SHIFT must be ignored; exactly one done.
        do_op("ignore", 8'h35, 8'h12, 3);
        count_done(W + 4, extra);
        check_eq("ignore_no_extra_done", extra, 0);

        // Reset in the middle of SHIFT.
        start = 1'b1;
        a = 8'h9C;
        b = 8'h47;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_diff", diff, 0);
        check_eq("midrst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check_eq("midrst_ovf", ovf, 0);
`endif
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        count_done(W + 4, extra);
        check_eq("midrst_no_done", extra, 0);
        do_op("after_rst", 8'h35, 8'h12, 0);

        // Back-to-back with start held high.
        start = 1'b1;
        a = 8'h5C;
        b = 8'h3A;
        for (int i = 0; i < 4 * (W + 2) + 2; i++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cyc.push_back(i);
                check_eq("b2b_diff", diff, ref_diff(8'h5C, 8'h3A));
            end
        end
        start = 1'b0;
        check_eq("b2b_count_ge3", (done_cyc.size() >= 3), 1);
        for (int i = 1; i < done_cyc.size(); i++) begin
            check_eq("b2b_period", done_cyc[i] - done_cyc[i-1], W + 2);
        end
        count_done(W + 4, extra);

        // Random sweep.
        for (int n = 0; n < N_RANDOM; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op("rand", ra, rb, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
